// File: rtl/caesar_pkg.sv
// caesar_pkg: shared state encoding and constants for the Caesar byte-shift engine
package caesar_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int KEY_SINGLE  = 0;
    localparam int KEY_PERBYTE = 1;
    localparam int BYTE_W      = 8;
endpackage

// File: rtl/caesar_byte_op.sv
// caesar_byte_op: one byte shifted by a key byte, modulo 256, either direction
module caesar_byte_op
    import caesar_pkg::*;
(
    input  logic [BYTE_W-1:0] data,
    input  logic [BYTE_W-1:0] shift,
    input  logic              decrypt,
    output logic [BYTE_W-1:0] result
);
    assign result = decrypt ? data - shift : data + shift;
endmodule

// File: rtl/caesar_stream.sv
// caesar_stream: multi-cycle Caesar byte-shift engine, LANES bytes per clock under valid/ready
module caesar_stream
    import caesar_pkg::*;
#(
    parameter int BLOCK_W  = 128,
    parameter int LANES    = 4,
    parameter int KEY_MODE = KEY_SINGLE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_block,
    input  logic [BLOCK_W-1:0] key,
    input  logic               decrypt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_block
);
    localparam int NBYTE = BLOCK_W / BYTE_W;
    localparam int NBEAT = BLOCK_W / (BYTE_W * LANES);
    localparam int CW    = $clog2(NBEAT) + 1;
    localparam int IW    = NBYTE > 1 ? $clog2(NBYTE) : 1;

    if (LANES < 1 || LANES > NBYTE || BLOCK_W % (BYTE_W * LANES) != 0) begin : g_bad_params
        $error("caesar_stream: BLOCK_W must be a multiple of 8*LANES with 1 <= LANES <= BLOCK_W/8");
    end

    state_t            state_q, state_d;
    logic [CW-1:0]     beat_q, beat_d;
    logic [BYTE_W-1:0] data_q [NBYTE];
    logic [BYTE_W-1:0] data_d [NBYTE];
    logic [BYTE_W-1:0] key_q  [NBYTE];
    logic [BYTE_W-1:0] key_d  [NBYTE];
    logic              dec_q, dec_d;
    logic [IW-1:0]     idx      [LANES];
    logic [BYTE_W-1:0] lane_out [LANES];

    // byte 0 is the MSB byte, so lane l of beat b works on byte b*LANES+l
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign idx[l] = IW'(int'(beat_q) * LANES + l);
        caesar_byte_op u_op (
            .data    (data_q[idx[l]]),
            .shift   (KEY_MODE == KEY_PERBYTE ? key_q[idx[l]] : key_q[0]),
            .decrypt (dec_q),
            .result  (lane_out[l])
        );
    end

    for (genvar i = 0; i < NBYTE; i++) begin : g_out
        assign out_block[BLOCK_W-1-BYTE_W*i -: BYTE_W] = data_q[i];
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;

    // Next state: capture a job in IDLE, transform one beat per RUN cycle in place, hold in DONE
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        data_d  = data_q;
        key_d   = key_q;
        dec_d   = dec_q;
        if (state_q == IDLE && in_valid) begin
            for (int i = 0; i < NBYTE; i++) begin
                data_d[i] = BYTE_W'(in_block >> (BLOCK_W - BYTE_W * (i + 1)));
                key_d[i]  = BYTE_W'(key >> (BLOCK_W - BYTE_W * (i + 1)));
            end
            dec_d   = decrypt;
            beat_d  = '0;
            state_d = RUN;
        end else if (state_q == RUN) begin
            for (int l = 0; l < LANES; l++) data_d[idx[l]] = lane_out[l];
            beat_d  = beat_q == CW'(NBEAT - 1) ? '0 : beat_q + CW'(1);
            state_d = beat_q == CW'(NBEAT - 1) ? DONE : RUN;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    // State and working registers; reset discards any job in flight and clears the result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            data_q  <= '{default: '0};
            key_q   <= '{default: '0};
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            data_q  <= data_d;
            key_q   <= key_d;
            dec_q   <= dec_d;
        end
    end
endmodule
